// File: rtl/flip_select_controller.sv
// Sequencer that fetches broken-clause bits per valid literal, writes them into the datapath and returns the selected flip index.
// Optional fetch watchdog with error_o pulse is enabled by defining FSC_TIMEOUT_EN.
module flip_select_controller #(
   parameter int NSAT    = 3,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start_i,
   input  logic [NSAT-1:0]          lit_valid_i,
   output logic                     fetch_req_o,
   output logic [$clog2(NSAT)-1:0]  fetch_idx_o,
   input  logic                     fetch_ack_i,
   output logic [$clog2(NSAT)-1:0]  wren_o,
   output logic [NSAT-1:0]          bv_valid_o,
   input  logic [$clog2(NSAT)-1:0]  sel_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [$clog2(NSAT)-1:0]  flip_idx_o
`ifdef FSC_TIMEOUT_EN
   ,
   output logic                     error_o
`endif
);

   localparam int IW = $clog2(NSAT);
   localparam logic [IW-1:0] LAST_IDX = IW'(NSAT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_WRITE  = 3'd2,
      S_SELECT = 3'd3,
      S_WAIT   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IW-1:0]     r_k;
   logic [IW-1:0]     w_k_nxt;
   logic [IW:0]       w_hit;
   logic              w_accept;
   logic              w_timeout;
   logic [IW-1:0]     w_wren_nxt;
   logic              w_busy_nxt;
   logic [NSAT-1:0]   r_bv_valid;

   // Lowest valid literal at or above lo, returned as {found, index}.
   function automatic logic [IW:0] find_from(input logic [NSAT-1:0] mask, input int lo);
      logic [IW:0] res;
      res = {1'b0, {IW{1'b0}}};
      for (int j = NSAT - 1; j >= 0; j--) begin
         if (j >= lo && mask[j]) begin
            res = {1'b1, IW'(j)};
         end
      end
      return res;
   endfunction

`ifdef FSC_TIMEOUT_EN
   logic [7:0] r_cnt;

   // Watchdog counts FETCH cycles without acknowledge, cleared on every FETCH entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= 8'd0;
      end else if (w_state_nxt == S_FETCH && r_state != S_FETCH) begin
         r_cnt <= 8'd0;
      end else if (r_state == S_FETCH && !fetch_ack_i) begin
         r_cnt <= r_cnt + 8'd1;
      end else begin
         r_cnt <= r_cnt;
      end
   end
`endif

   // Next-state logic; outputs are derived from the next state so they register in step with it.
   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_hit       = {1'b0, {IW{1'b0}}};
      w_accept    = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_accept = 1'b1;
               w_hit    = find_from(lit_valid_i, 0);
               if (w_hit[IW]) begin
                  w_state_nxt = S_FETCH;
                  w_k_nxt     = w_hit[IW-1:0];
               end else begin
                  w_state_nxt = S_SELECT;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_FETCH: begin
            if (fetch_ack_i) begin
               if (r_k == LAST_IDX) begin
                  w_state_nxt = S_SELECT;
               end else begin
                  w_state_nxt = S_WRITE;
               end
            end else begin
`ifdef FSC_TIMEOUT_EN
               if ((32'(r_cnt) + 32'd1) >= 32'(TIMEOUT)) begin
                  w_timeout   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_FETCH;
               end
`else
               w_state_nxt = S_FETCH;
`endif
            end
         end
         S_WRITE: begin
            w_hit = find_from(r_bv_valid, int'(r_k) + 1);
            if (w_hit[IW]) begin
               w_state_nxt = S_FETCH;
               w_k_nxt     = w_hit[IW-1:0];
            end else begin
               w_state_nxt = S_SELECT;
            end
         end
         S_SELECT: w_state_nxt = S_WAIT;
         S_WAIT:   w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase

      w_wren_nxt = {IW{1'b0}};
      if (w_state_nxt == S_WRITE) begin
         w_wren_nxt = IW'(1) << w_k_nxt;
      end else if (w_state_nxt == S_SELECT) begin
         w_wren_nxt = {IW{1'b1}};
      end else begin
         w_wren_nxt = {IW{1'b0}};
      end
      w_busy_nxt = (w_state_nxt == S_FETCH) || (w_state_nxt == S_WRITE) ||
                   (w_state_nxt == S_SELECT) || (w_state_nxt == S_WAIT);
   end

   // State register and sequence index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_k     <= {IW{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_req_o <= 1'b0;
         fetch_idx_o <= {IW{1'b0}};
         wren_o      <= {IW{1'b0}};
         r_bv_valid  <= {NSAT{1'b0}};
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         flip_idx_o  <= {IW{1'b0}};
`ifdef FSC_TIMEOUT_EN
         error_o     <= 1'b0;
`endif
      end else begin
         fetch_req_o <= (w_state_nxt == S_FETCH);
         fetch_idx_o <= w_k_nxt;
         wren_o      <= w_wren_nxt;
         r_bv_valid  <= w_accept ? lit_valid_i : r_bv_valid;
         busy_o      <= w_busy_nxt;
         done_o      <= (w_state_nxt == S_DONE);
         flip_idx_o  <= (r_state == S_WAIT) ? sel_i : flip_idx_o;
`ifdef FSC_TIMEOUT_EN
         error_o     <= w_timeout;
`endif
      end
   end

   assign bv_valid_o = r_bv_valid;

endmodule

// File: tb/tb_flip_select_controller.sv
// Directed bench for flip_select_controller (NSAT=3, TIMEOUT=4); the watchdog case runs when FSC_TIMEOUT_EN is defined.
module tb_flip_select_controller;

   logic       clk;
   logic       reset;
   logic       start_i;
   logic [2:0] lit_valid_i;
   logic       fetch_req_o;
   logic [1:0] fetch_idx_o;
   logic       fetch_ack_i;
   logic [1:0] wren_o;
   logic [2:0] bv_valid_o;
   logic [1:0] sel_i;
   logic       busy_o;
   logic       done_o;
   logic [1:0] flip_idx_o;
`ifdef FSC_TIMEOUT_EN
   logic       error_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [1:0] exp_wren [0:15];
   logic       req_log  [0:15];
   logic [1:0] idx_log  [0:15];

   flip_select_controller #(.NSAT(3), .TIMEOUT(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_i     (start_i),
      .lit_valid_i (lit_valid_i),
      .fetch_req_o (fetch_req_o),
      .fetch_idx_o (fetch_idx_o),
      .fetch_ack_i (fetch_ack_i),
      .wren_o      (wren_o),
      .bv_valid_o  (bv_valid_o),
      .sel_i       (sel_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .flip_idx_o  (flip_idx_o)
`ifdef FSC_TIMEOUT_EN
      ,
      .error_o     (error_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_exp();
      for (int i = 0; i < 16; i++) exp_wren[i] = 2'b00;
   endtask

   // Start in cycle 0; ack is low on cycles [lo_start, lo_start+lo_len).
   task automatic run_clause(input string tag, input logic [2:0] mask, input logic [1:0] sel,
                             input int lo_start, input int lo_len, input bit poke, input int exp_done);
      int done_cyc;
      int done_cnt;
      bit saw_idx1;
      done_cyc = 0;
      done_cnt = 0;
      saw_idx1 = 1'b0;
      lit_valid_i = mask;
      sel_i       = sel;
      fetch_ack_i = 1'b1;
      start_i     = 1'b1;
      tick();
      start_i = 1'b0;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         req_log[cyc] = fetch_req_o;
         idx_log[cyc] = fetch_idx_o;
         check_eq({tag, "_wren"}, 32'(wren_o), 32'(exp_wren[cyc]));
         if (done_o) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = cyc;
         end
         if (fetch_req_o && fetch_idx_o == 2'd1) saw_idx1 = 1'b1;
         if (cyc == 1) check_eq({tag, "_busy_c1"}, 32'(busy_o), 32'd1);
         if (cyc == exp_done - 1) check_eq({tag, "_busy_pre"}, 32'(busy_o), 32'd1);
         if (cyc == exp_done) begin
            check_eq({tag, "_busy_done"}, 32'(busy_o), 32'd0);
            check_eq({tag, "_bv_valid"}, 32'(bv_valid_o), 32'(mask));
         end
         fetch_ack_i = !(cyc >= lo_start && cyc < lo_start + lo_len);
         start_i = poke && (cyc == 2 || done_o);
         if (poke && cyc == 2) lit_valid_i = 3'b010;
         tick();
      end
      start_i     = 1'b0;
      fetch_ack_i = 1'b1;
      check_eq({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
      check_eq({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      check_eq({tag, "_flip_idx"}, 32'(flip_idx_o), 32'(sel));
      check_eq({tag, "_busy_end"}, 32'(busy_o), 32'd0);
      check_eq({tag, "_fetch1"}, 32'(saw_idx1), 32'(mask[1]));
   endtask

   initial begin
      reset = 1'b1;
      start_i = 1'b0;
      lit_valid_i = 3'b000;
      fetch_ack_i = 1'b0;
      sel_i = 2'b00;
      #23;
      check_eq("rst_req", 32'(fetch_req_o), 32'd0);
      check_eq("rst_idx", 32'(fetch_idx_o), 32'd0);
      check_eq("rst_wren", 32'(wren_o), 32'd0);
      check_eq("rst_bv", 32'(bv_valid_o), 32'd0);
      check_eq("rst_busy", 32'(busy_o), 32'd0);
      check_eq("rst_done", 32'(done_o), 32'd0);
      check_eq("rst_flip", 32'(flip_idx_o), 32'd0);
      reset = 1'b0;
      tick();

      clear_exp(); exp_wren[2] = 2'b01; exp_wren[4] = 2'b10; exp_wren[6] = 2'b11;
      run_clause("basic", 3'b111, 2'b10, 0, 0, 1'b1, 8);

      clear_exp(); exp_wren[2] = 2'b01; exp_wren[7] = 2'b10; exp_wren[9] = 2'b11;
      run_clause("stall", 3'b111, 2'b01, 3, 3, 1'b0, 11);
      for (int c = 3; c <= 6; c++) begin
         check_eq("stall_req_hold", 32'(req_log[c]), 32'd1);
         check_eq("stall_idx_hold", 32'(idx_log[c]), 32'd1);
      end
      check_eq("stall_req_drop", 32'(req_log[7]), 32'd0);

      clear_exp(); exp_wren[2] = 2'b01; exp_wren[4] = 2'b11;
      run_clause("skip101", 3'b101, 2'b00, 0, 0, 1'b0, 6);
      check_eq("skip101_idx_c3", 32'(idx_log[3]), 32'd2);

      clear_exp(); exp_wren[1] = 2'b11;
      run_clause("none", 3'b000, 2'b01, 0, 0, 1'b0, 3);

      clear_exp(); exp_wren[2] = 2'b11;
      run_clause("only2", 3'b100, 2'b10, 0, 0, 1'b0, 4);
      check_eq("only2_idx_c1", 32'(idx_log[1]), 32'd2);

      clear_exp(); exp_wren[2] = 2'b10; exp_wren[3] = 2'b11;
      run_clause("only1", 3'b010, 2'b00, 0, 0, 1'b0, 5);

      // Reset asserted during SELECT.
      lit_valid_i = 3'b111; sel_i = 2'b11; fetch_ack_i = 1'b1; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int c = 1; c < 6; c++) tick();
      check_eq("mid_select_wren", 32'(wren_o), 32'd3);
      #2 reset = 1'b1;
      #1;
      check_eq("mid_rst_wren", 32'(wren_o), 32'd0);
      check_eq("mid_rst_busy", 32'(busy_o), 32'd0);
      check_eq("mid_rst_bv", 32'(bv_valid_o), 32'd0);
      check_eq("mid_rst_req", 32'(fetch_req_o), 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check_eq("mid_rst_done", 32'(done_o), 32'd0);
      end
      reset = 1'b0;
      tick();
      clear_exp(); exp_wren[2] = 2'b01; exp_wren[4] = 2'b10; exp_wren[6] = 2'b11;
      run_clause("after_rst", 3'b111, 2'b01, 0, 0, 1'b0, 8);

`ifdef FSC_TIMEOUT_EN
      lit_valid_i = 3'b111; sel_i = 2'b10; fetch_ack_i = 1'b0; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         if (c <= 4) begin
            check_eq("to_req", 32'(fetch_req_o), 32'd1);
            check_eq("to_err_early", 32'(error_o), 32'd0);
         end else if (c == 5) begin
            check_eq("to_err", 32'(error_o), 32'd1);
            check_eq("to_busy", 32'(busy_o), 32'd0);
            check_eq("to_req_drop", 32'(fetch_req_o), 32'd0);
         end else begin
            check_eq("to_err_pulse", 32'(error_o), 32'd0);
         end
         tick();
      end
      check_eq("to_flip_kept", 32'(flip_idx_o), 32'd1);
      fetch_ack_i = 1'b1;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/flip_select_controller.md
FLIP_SELECT_CONTROLLER -- requirements
Module: flip_select_controller

Interface
REQ-001 The block SHALL have parameter NSAT, default 3, meaning literals per clause; legal values are 2 and 3.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the fetch watchdog limit in cycles (8-bit counter).
REQ-003 The block SHALL have the following ports, in this order:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle request to evaluate one unsatisfied clause.
- lit_valid_i  in  NSAT  per-literal present mask, sampled with start_i.
- fetch_req_o  out  1  request for the broken-clause bits of literal fetch_idx_o.
- fetch_idx_o  out  $clog2(NSAT)  literal index being fetched.
- fetch_ack_i  in  1  fetched bits are valid on the datapath inputs this cycle and are held until the next fetch_req_o.
- wren_o  out  $clog2(NSAT)  datapath write-enable code: 0 idle, 1<<k write row k, all-ones select.
- bv_valid_o  out  NSAT  break-value valid mask for the selector.
- sel_i  in  $clog2(NSAT)  registered selected index returned by the datapath.
- busy_o  out  1  high from the start accept until done_o or error_o.
- done_o  out  1  one-cycle completion pulse.
- flip_idx_o  out  $clog2(NSAT)  chosen literal, held until the next done_o.
- error_o  out  1  one-cycle fetch-timeout pulse; exists only with FSC_TIMEOUT_EN.

Function
REQ-004 The FSM SHALL have states IDLE, FETCH, WRITE, SELECT, WAIT and DONE; all outputs SHALL be registered.
REQ-005 In IDLE, start_i=1 SHALL latch lit_valid_i into bv_valid_o, assert busy_o and go to FETCH with k set to the lowest valid index; start_i SHALL be ignored while busy_o=1.
REQ-006 Skipping: if no literal below NSAT-1 is valid and literal NSAT-1 is invalid, the FSM SHALL go directly to SELECT.
REQ-007 In FETCH, fetch_req_o SHALL be 1 and fetch_idx_o SHALL equal k; both SHALL be held until fetch_ack_i=1.
REQ-008 On acknowledge with k<NSAT-1, the FSM SHALL enter WRITE for exactly one cycle with wren_o=1<<k and fetch_req_o=0.
REQ-009 After WRITE, the FSM SHALL go to FETCH for the next valid index above k. Literal NSAT-1 SHALL be fetched only if it is valid; otherwise the FSM SHALL go to SELECT.
REQ-010 On acknowledge with k=NSAT-1, the FSM SHALL go to SELECT.
REQ-011 SELECT SHALL last exactly one cycle with wren_o all-ones; it SHALL be followed by WAIT for one cycle with wren_o=0.
REQ-012 At the WAIT->DONE edge, flip_idx_o SHALL load sel_i.
REQ-013 In DONE, done_o=1 and busy_o=0 for one cycle, then the FSM SHALL return to IDLE; a start_i during DONE SHALL be ignored.
REQ-014 wren_o SHALL never be one-hot and all-ones in the same cycle, and SHALL be 0 outside WRITE and SELECT.
REQ-015 With all literals valid and fetch_ack_i tied to 1, start-to-done_o latency SHALL be 2*NSAT+2 cycles; each extra wait cycle on acknowledge SHALL add exactly one cycle.
REQ-016 fetch_ack_i outside FETCH SHALL be ignored.

Reset
REQ-017 Reset SHALL asynchronously force IDLE and these output values: fetch_req_o=0, fetch_idx_o=0, wren_o=0, bv_valid_o=0, busy_o=0, done_o=0, flip_idx_o=0, error_o=0, and watchdog counter=0.
REQ-018 Reset asserted mid-sequence SHALL abandon the clause with no done_o; the first start_i after release SHALL be processed normally.

Configuration
REQ-019 With macro FSC_TIMEOUT_EN defined:
- An 8-bit counter SHALL clear on entry to FETCH and increment each FETCH cycle without acknowledge.
- When the counter reaches TIMEOUT, the FSM SHALL pulse error_o, drop busy_o and fetch_req_o, return to IDLE, and leave flip_idx_o unchanged.
REQ-020 Without FSC_TIMEOUT_EN, the error_o port and the counter SHALL be absent, and FETCH SHALL wait indefinitely.

Verification
REQ-021 Basic flow: NSAT=3, lit_valid=111, ack tied 1, sel_i=10 -> wren_o sequence 01,10,11 on cycles 2,4,6; done_o on cycle 8; flip_idx_o=10.
REQ-022 Acknowledge stall: ack for literal 1 delayed 3 cycles -> fetch_idx_o held at 1 with fetch_req_o=1 throughout; done_o at cycle 11.
REQ-023 Skip: lit_valid=101 -> no wren_o=10 cycle, no fetch of index 1, bv_valid_o=101; done_o at cycle 6.
REQ-024 Reset during SELECT -> all outputs 0 immediately; no done_o; next start completes normally.
REQ-025 Timeout: FSC_TIMEOUT_EN, TIMEOUT=4, ack never -> error_o pulses after 4 FETCH cycles; busy_o=0; flip_idx_o unchanged.
REQ-026 start_i pulsed while busy_o=1 or in DONE -> ignored; exactly one done_o per accepted start.
